serial_feeder: RTL

SERIAL_FEEDER -- requirements
Module: serial_feeder

---
 rtl/serial_feeder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/serial_feeder.sv
// Parallel-to-serial feeder for a downstream pattern detector: MSB first, gapless back-to-back words.
// Optional feature: define SER_PARITY_EN to append one even-parity bit after each word.
module serial_feeder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             din,
    output logic             valid,
    output logic             busy,
    output logic             word_done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             din_q, valid_q, busy_q, word_done_q;
    logic             din_d, word_done_d;
    logic             transfer;
`ifdef SER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // data_ready depends only on reset, state and bit count, never on data_valid.
    always_comb begin
        data_ready = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE:    data_ready = 1'b1;
`ifdef SER_PARITY_EN
                PARITY:  data_ready = 1'b1;
`else
                SHIFT:   data_ready = (cnt_q == LAST);
`endif
                default: data_ready = 1'b0;
            endcase
        end
    end

    assign transfer = data_valid && data_ready;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
`ifdef SER_PARITY_EN
        parity_d = parity_q;
`endif
        if (transfer) begin
            state_d = SHIFT;
            shift_d = data_in;
            cnt_d   = '0;
`ifdef SER_PARITY_EN
            parity_d = ^data_in;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    if (cnt_q == LAST) begin
`ifdef SER_PARITY_EN
                        state_d = PARITY;
                        cnt_d   = cnt_q + CNT_W'(1);
`else
                        state_d = IDLE;
`endif
                    end else begin
                        shift_d = {shift_q[WIDTH-2:0], 1'b0};
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
`ifdef SER_PARITY_EN
                PARITY:  state_d = IDLE;
`endif
                default: state_d = IDLE;
            endcase
        end

        din_d       = 1'b0;
        word_done_d = 1'b0;
        if (state_d == SHIFT) begin
            din_d = shift_d[WIDTH-1];
`ifndef SER_PARITY_EN
            word_done_d = (cnt_d == LAST);
`endif
        end
`ifdef SER_PARITY_EN
        if (state_d == PARITY) begin
            din_d       = parity_d;
            word_done_d = 1'b1;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            din_q       <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            word_done_q <= 1'b0;
`ifdef SER_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            din_q       <= din_d;
            valid_q     <= (state_d != IDLE);
            busy_q      <= (state_d != IDLE);
            word_done_q <= word_done_d;
`ifdef SER_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign din       = din_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign word_done = word_done_q;

endmodule
